imem_load_arbiter: RTL and testbench

//  Owns the single port of the instruction memory and shares it between two

---
 rtl/imem_load_arbiter_pkg.sv | 14 +
 rtl/imem_load_timer.sv | 42 ++++
 rtl/imem_load_arbiter.sv | 136 +++++++++++++
 tb/tb_imem_load_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_load_arbiter_pkg.sv
// Shared definitions for the instruction-memory load arbiter: the filler
// instruction and the arbiter state encoding.
package imem_load_arbiter_pkg;

    // addi x0,x0,0: delivered to decode whenever no real instruction is available
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/imem_load_timer.sv
// Idle-cycle watchdog for load mode. Counts consecutive cycles without a
// loader transfer and flags expiry on the TIMEOUT-th idle cycle.
// TIMEOUT = 0 removes the counter entirely and never expires.
module imem_load_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expire
);

    generate
        if (TIMEOUT == 0) begin : g_disabled
            logic w_unused_ok;
            assign w_unused_ok = ^{i_clk, i_rst, i_clear, i_inc};
            assign o_expire    = 1'b0;
        end else begin : g_enabled
            localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

            logic [TW-1:0] r_count;
            logic          w_expire;

            // Expiry happens on the idle cycle that would take the count to TIMEOUT
            assign w_expire = i_inc && (r_count == TW'(TIMEOUT - 1));
            assign o_expire = w_expire;

            // Idle counter: cleared by reset, by the owner, or on expiry
            always_ff @(posedge i_clk) begin
                // NOTE: sequential state uses non-blocking assignments so every
                // register samples pre-edge values regardless of block order.
                if (i_rst || i_clear || w_expire) begin
                    r_count <= '0;
                end else if (i_inc) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/imem_load_arbiter.sv
// Instruction-memory port arbiter: the fetch path reads the memory
// combinationally in RUN; an external loader takes the port in LOAD while the
// core is stalled; FLUSH issues a single restart pulse before returning to RUN.
module imem_load_arbiter
    import imem_load_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [31:0]       i_fetch_pc,
    output logic [DATA_W-1:0] o_fetch_instr,
    output logic              o_fetch_fault,
    output logic              o_cpu_stall,
    output logic              o_cpu_restart,
    input  logic              i_ld_start,
    input  logic              i_ld_valid,
    output logic              o_ld_ready,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_data,
    input  logic              i_ld_last,
    output logic              o_ld_done,
    output logic              o_ld_error,
    output logic [ADDR_W:0]   o_ld_count,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    // Count saturates at the memory depth
    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t          r_state;
    state_t          w_next_state;
    logic            r_ld_done;
    logic            r_ld_error;
    logic [ADDR_W:0] r_ld_count;

    logic w_pc_out_of_range;
    logic w_enter_load;
    logic w_xfer;
    logic w_timer_inc;
    logic w_timer_expire;

    assign w_pc_out_of_range = |i_fetch_pc[31:ADDR_W];
    assign w_enter_load      = (r_state == ST_RUN) && i_ld_start;
    assign w_xfer            = (r_state == ST_LOAD) && i_ld_valid;
    assign w_timer_inc       = (r_state == ST_LOAD) && !i_ld_valid;

    imem_load_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (w_enter_load || w_xfer),
        .i_inc    (w_timer_inc),
        .o_expire (w_timer_expire)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        w_next_state = r_state;
        case (r_state)
            ST_RUN:   if (i_ld_start) w_next_state = ST_LOAD;
            ST_LOAD:  if ((w_xfer && i_ld_last) || w_timer_expire) w_next_state = ST_FLUSH;
            ST_FLUSH: w_next_state = ST_RUN;
            default:  w_next_state = ST_RUN;
        endcase
    end

    // Port mux and core control for the current state
    always_comb begin
        o_fetch_instr = DATA_W'(NOP_INSTR);
        o_fetch_fault = 1'b0;
        o_cpu_stall   = 1'b1;
        o_cpu_restart = 1'b0;
        o_ld_ready    = 1'b0;
        o_mem_addr    = i_fetch_pc[ADDR_W-1:0];
        o_mem_we      = 1'b0;
        case (r_state)
            ST_RUN: begin
                o_cpu_stall   = 1'b0;
                o_fetch_fault = w_pc_out_of_range;
                if (!w_pc_out_of_range) o_fetch_instr = i_mem_rdata;
            end
            ST_LOAD: begin
                o_ld_ready = 1'b1;
                o_mem_we   = i_ld_valid;
                if (i_ld_valid) o_mem_addr = i_ld_addr;
            end
            ST_FLUSH: begin
                o_cpu_restart = 1'b1;
            end
            default: ;
        endcase
    end

    // Write data is always the loader word; only mem_we qualifies it
    assign o_mem_wdata = i_ld_data;

    // Load status: cleared on entry to LOAD, updated by transfers, timeout and flush
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ld_done  <= 1'b0;
            r_ld_error <= 1'b0;
            r_ld_count <= '0;
        end else if (w_enter_load) begin
            r_ld_done  <= 1'b0;
            r_ld_error <= 1'b0;
            r_ld_count <= '0;
        end else begin
            if (w_xfer && (r_ld_count != COUNT_MAX)) r_ld_count <= r_ld_count + 1'b1;
            if (w_timer_expire) r_ld_error <= 1'b1;
            if ((r_state == ST_FLUSH) && !r_ld_error) r_ld_done <= 1'b1;
        end
    end

    assign o_ld_done  = r_ld_done;
    assign o_ld_error = r_ld_error;
    assign o_ld_count = r_ld_count;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Self-checking bench for imem_load_arbiter: a behavioural memory on the port,
// directed scenarios plus randomized loads checked against a word-level model.
module tb_imem_load_arbiter;
    import imem_load_arbiter_pkg::*;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 512;
    localparam int TMO    = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk;
    logic              rst;
    logic [31:0]       fetch_pc;
    logic [DATA_W-1:0] fetch_instr;
    logic              fetch_fault;
    logic              cpu_stall;
    logic              cpu_restart;
    logic              ld_start;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_done;
    logic              ld_error;
    logic [ADDR_W:0]   ld_count;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    imem_load_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TMO)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_fetch_pc    (fetch_pc),
        .o_fetch_instr (fetch_instr),
        .o_fetch_fault (fetch_fault),
        .o_cpu_stall   (cpu_stall),
        .o_cpu_restart (cpu_restart),
        .i_ld_start    (ld_start),
        .i_ld_valid    (ld_valid),
        .o_ld_ready    (ld_ready),
        .i_ld_addr     (ld_addr),
        .i_ld_data     (ld_data),
        .i_ld_last     (ld_last),
        .o_ld_done     (ld_done),
        .o_ld_error    (ld_error),
        .o_ld_count    (ld_count),
        .o_mem_addr    (mem_addr),
        .o_mem_we      (mem_we),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rdata   (mem_rdata)
    );

    // Behavioural instruction memory: combinational read, clocked write,
    // plus a bench-side preload port
    logic [DATA_W-1:0] mem [DEPTH];
    logic              pre_en;
    logic [ADDR_W-1:0] pre_addr;
    logic [DATA_W-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: memory image as the loader should have left it, plus status
    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                ref_known [DEPTH];
    int                known_q [$];
    int                exp_count;
    bit                exp_done;
    bit                exp_err;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_done"},  ld_done,  exp_done);
        check({tag, "_error"}, ld_error, exp_err);
        check({tag, "_count"}, ld_count, exp_count);
    endtask

    // RUN-mode fetch of a word-index; expected value from the model image
    task automatic check_fetch(input logic [31:0] pc);
        fetch_pc = pc;
        #1;
        check("fetch_stall", cpu_stall, 0);
        check("fetch_we", mem_we, 0);
        if (pc >= DEPTH) begin
            check("fetch_fault_oor", fetch_fault, 1);
            check("fetch_instr_oor", fetch_instr, NOP);
        end else begin
            check("fetch_fault_in", fetch_fault, 0);
            if (ref_known[pc]) check("fetch_instr", fetch_instr, ref_mem[pc]);
        end
    endtask

    // One loader word accepted in LOAD
    task automatic xfer(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit last);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        ld_last  = last;
        #1;
        check("xfer_we", mem_we, 1);
        check("xfer_addr", mem_addr, a);
        check("xfer_wdata", mem_wdata, d);
        tick();
        ref_mem[a] = d;
        if (!ref_known[a]) known_q.push_back(int'(a));
        ref_known[a] = 1'b1;
        if (exp_count < DEPTH) exp_count++;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("xfer_count", ld_count, exp_count);
    endtask

    // Full load: start request, words with random idle gaps, flush, back to RUN.
    // With hold_first, the first word is already offered in RUN and must not be taken there.
    task automatic do_load(input logic [ADDR_W-1:0] addrs[$], input logic [DATA_W-1:0] datas[$],
                           input int max_gap, input bit hold_first);
        ld_start = 1'b1;
        if (hold_first) begin
            ld_valid = 1'b1;
            ld_addr  = addrs[0];
            ld_data  = datas[0];
        end
        #1;
        check("run_ready", ld_ready, 0);
        check("run_we", mem_we, 0);
        check("run_stall", cpu_stall, 0);
        tick();
        ld_start  = 1'b0;
        exp_count = 0;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        fetch_pc  = 32'hFFFF_FFFF;
        ld_valid  = 1'b0;
        #1;
        check("load_stall", cpu_stall, 1);
        check("load_ready", ld_ready, 1);
        check("load_instr", fetch_instr, NOP);
        check("load_fault", fetch_fault, 0);
        check_status("load_entry");
        for (int i = 0; i < addrs.size(); i++) begin
            int gaps = (hold_first && i == 0) ? 0 : int'($urandom_range(max_gap));
            for (int g = 0; g < gaps; g++) begin
                ld_valid = 1'b0;
                ld_last  = 1'($urandom_range(1));
                ld_start = 1'($urandom_range(1));
                #1;
                check("gap_we", mem_we, 0);
                check("gap_ready", ld_ready, 1);
                tick();
                ld_start = 1'b0;
                ld_last  = 1'b0;
            end
            xfer(addrs[i], datas[i], i == addrs.size() - 1);
        end
        ld_start = 1'b1;
        #1;
        check("flush_restart", cpu_restart, 1);
        check("flush_stall", cpu_stall, 1);
        check("flush_ready", ld_ready, 0);
        check("flush_we", mem_we, 0);
        check("flush_instr", fetch_instr, NOP);
        tick();
        ld_start = 1'b0;
        exp_done = 1'b1;
        fetch_pc = 32'd0;
        #1;
        check("post_restart", cpu_restart, 0);
        check("post_stall", cpu_stall, 0);
        check_status("post_load");
    endtask

    logic [ADDR_W-1:0] q_addr [$];
    logic [DATA_W-1:0] q_data [$];
    logic [DATA_W-1:0] w511;

    initial begin
        rst      = 1'b1;
        fetch_pc = 32'd0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        ld_last  = 1'b0;
        exp_count = 0;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;

        // Reset with memory preload of words 1 and 511
        w511     = $urandom;
        pre_en   = 1'b1;
        pre_addr = 9'd1;
        pre_data = 32'h0010_8113;
        tick();
        pre_addr = 9'd511;
        pre_data = w511;
        tick();
        pre_en = 1'b0;
        ref_mem[1]   = 32'h0010_8113;
        ref_known[1] = 1'b1;
        ref_mem[511]   = w511;
        ref_known[511] = 1'b1;
        check("rst_stall", cpu_stall, 0);
        check("rst_restart", cpu_restart, 0);
        check("rst_ready", ld_ready, 0);
        check("rst_we", mem_we, 0);
        check_status("rst");
        rst = 1'b0;
        tick();

        // Zero-latency fetch and range boundaries
        check_fetch(32'd1);
        check_fetch(32'd511);
        check_fetch(32'd512);
        check_fetch(32'hFFFF_FFFF);
        check_fetch(32'h0000_0200 | $urandom);

        // Three-word image, no gaps
        q_addr = '{9'd0, 9'd1, 9'd2};
        q_data = '{32'h0031_01B3, 32'h0030_2123, 32'hFE42_0AE3};
        do_load(q_addr, q_data, 0, 1'b0);
        check_fetch(32'd2);
        check_fetch(32'd0);

        // Valid offered in RUN, gapped transfers, random stray ld_last/ld_start
        q_addr.delete();
        q_data.delete();
        for (int i = 0; i < 6; i++) begin
            q_addr.push_back(ADDR_W'($urandom));
            q_data.push_back($urandom);
        end
        do_load(q_addr, q_data, 3, 1'b1);
        for (int i = 0; i < 6; i++) check_fetch(32'(q_addr[i]));

        // Timeout: no loader words for TMO cycles
        ld_start = 1'b1;
        tick();
        ld_start  = 1'b0;
        exp_count = 0;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        for (int k = 1; k < TMO; k++) begin
            tick();
            check("tmo_wait_ready", ld_ready, 1);
        end
        tick();
        exp_err = 1'b1;
        check("tmo_restart", cpu_restart, 1);
        check("tmo_ready", ld_ready, 0);
        check_status("tmo_flush");
        tick();
        check("tmo_run_stall", cpu_stall, 0);
        check_status("tmo_run");

        // Reset in the middle of a four-word load
        ld_start = 1'b1;
        tick();
        ld_start  = 1'b0;
        exp_count = 0;
        exp_err   = 1'b0;
        xfer(9'd10, $urandom, 1'b0);
        xfer(9'd11, $urandom, 1'b0);
        rst = 1'b1;
        tick();
        exp_count = 0;
        check("rst_mid_stall", cpu_stall, 0);
        check("rst_mid_restart", cpu_restart, 0);
        check_status("rst_mid");
        rst = 1'b0;
        check_fetch(32'd10);
        check_fetch(32'd11);

        // Overlong image: count saturates at the memory depth
        q_addr.delete();
        q_data.delete();
        for (int i = 0; i < DEPTH + 2; i++) begin
            q_addr.push_back(ADDR_W'($urandom));
            q_data.push_back($urandom);
        end
        do_load(q_addr, q_data, 0, 1'b0);
        check("sat_count", ld_count, DEPTH);

        // Random read-back of the image
        for (int i = 0; i < 24; i++) begin
            check_fetch(32'(known_q[$urandom_range(known_q.size() - 1)]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
